// File: rtl/snn_pkg.sv
// snn_pkg: shared widths, FSM state type and signed saturation for the synapse and neuron blocks.
package snn_pkg;
  localparam int DEF_W_WIDTH = 16;
  localparam int DEF_OUT_WIDTH = 16;
  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;
  function automatic int acc_width(input int w, input int n);
    return w + $clog2(n) + 1;
  endfunction
  localparam int DEF_ACC_WIDTH = acc_width(DEF_W_WIDTH, 8);
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int ow);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/synapse_accumulator_if.sv
// synapse_accumulator_if: timestep strobe, spike vector, weight write port and neuron-facing result.
interface synapse_accumulator_if #(
    parameter int N_IN = 8,
    parameter int W_WIDTH = 16,
    parameter int OUT_WIDTH = 16
);
  logic start;
  logic [N_IN-1:0] in_spikes;
  logic wr_en;
  logic [$clog2(N_IN)-1:0] wr_addr;
  logic signed [W_WIDTH-1:0] wr_data;
  logic signed [OUT_WIDTH-1:0] spiking_value;
  logic out_valid;
  logic busy;
  modport master (
      output start, in_spikes, wr_en, wr_addr, wr_data,
      input spiking_value, out_valid, busy
  );
  modport slave (
      input start, in_spikes, wr_en, wr_addr, wr_data,
      output spiking_value, out_valid, busy
  );
endinterface

// File: rtl/synapse_weight_rf.sv
// synapse_weight_rf: N_IN x W_WIDTH weight file, sync write, async read returning old data on collision.
module synapse_weight_rf #(
    parameter int N_IN = 8,
    parameter int W_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(N_IN)-1:0]    wr_addr,
    input  logic signed [W_WIDTH-1:0]  wr_data,
    input  logic [$clog2(N_IN)-1:0]    rd_addr,
    output logic signed [W_WIDTH-1:0]  rd_data
);
    logic signed [W_WIDTH-1:0] mem [N_IN];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_IN; i++) mem[i] <= '0;
        end else if (wr_en && 32'(wr_addr) < N_IN) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/synapse_accumulator.sv
// synapse_accumulator: per-timestep weighted spike sum, one synapse per cycle, saturated to OUT_WIDTH.
// Optional leak subtraction before saturation is enabled by defining SYN_LEAK_EN.
module synapse_accumulator
    import snn_pkg::*;
#(
    parameter int N_IN = 8,
    parameter int W_WIDTH = DEF_W_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
`ifdef SYN_LEAK_EN
    ,
    parameter int LEAK = 4
`endif
) (
    input logic clk,
    input logic rst,
    synapse_accumulator_if.slave bus
);
    localparam int AW = $clog2(N_IN);
    localparam int ACC_W = acc_width(W_WIDTH, N_IN);

    state_t state;
    logic [AW-1:0] idx;
    logic [N_IN-1:0] spk_q;
    logic signed [ACC_W-1:0] acc;
    logic signed [W_WIDTH-1:0] w_rd;
    logic signed [63:0] emit_val;

    synapse_weight_rf #(.N_IN(N_IN), .W_WIDTH(W_WIDTH)) u_rf (
        .clk(clk),
        .rst(rst),
        .wr_en(bus.wr_en),
        .wr_addr(bus.wr_addr),
        .wr_data(bus.wr_data),
        .rd_addr(idx),
        .rd_data(w_rd)
    );

`ifdef SYN_LEAK_EN
    assign emit_val = sat(64'(acc) - 64'(LEAK), OUT_WIDTH);
`else
    assign emit_val = sat(64'(acc), OUT_WIDTH);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            idx <= '0;
            spk_q <= '0;
            acc <= '0;
            bus.spiking_value <= '0;
            bus.out_valid <= 1'b0;
            bus.busy <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    spk_q <= bus.in_spikes;
                    acc <= '0;
                    idx <= '0;
                    bus.busy <= 1'b1;
                    state <= ACCUM;
                end
                ACCUM: begin
                    if (spk_q[idx]) acc <= acc + ACC_W'(w_rd);
                    idx <= idx + 1'b1;
                    if (idx == AW'(N_IN - 1)) state <= EMIT;
                end
                EMIT: begin
                    bus.spiking_value <= OUT_WIDTH'(emit_val);
                    bus.out_valid <= 1'b1;
                    bus.busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_synapse_accumulator.sv
// tb_synapse_accumulator: table vectors, hand-written corner sequences and random timesteps vs a sum model.
module tb_synapse_accumulator;
    localparam int N = 8;
`ifdef SYN_LEAK_EN
    localparam int LEAK_V = 4;
`else
    localparam int LEAK_V = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    synapse_accumulator_if #(.N_IN(N), .W_WIDTH(16), .OUT_WIDTH(16)) bus ();
    synapse_accumulator #(.N_IN(N), .W_WIDTH(16), .OUT_WIDTH(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int w_model[N];

    typedef struct {
        logic [7:0] spk;
        int wmul;
        int wadd;
        int raw;
    } vec_t;
    vec_t vecs[6];

    function automatic int clamp(input int v);
        return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
    endfunction

    function automatic int expect_of(input logic [7:0] spk);
        int s = 0;
        for (int i = 0; i < N; i++) if (spk[i]) s += w_model[i];
        return clamp(s - LEAK_V);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_w(input int a, input int d);
        bus.wr_en = 1'b1;
        bus.wr_addr = 3'(a);
        bus.wr_data = 16'(d);
        tick();
        bus.wr_en = 1'b0;
        w_model[a] = d;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_ts(input logic [7:0] spk, output int lat);
        int l;
        bus.start = 1'b1;
        bus.in_spikes = spk;
        tick();
        bus.start = 1'b0;
        bus.in_spikes = 8'($urandom);
        wait_valid(l);
        lat = l;
    endtask

    initial begin
        int lat, pulses, val;
        logic [7:0] spk;
        bus.start = 1'b0;
        bus.in_spikes = '0;
        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        for (int i = 0; i < N; i++) w_model[i] = 0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("reset spiking_value", int'(bus.spiking_value), 0);
        chk("reset out_valid", int'(bus.out_valid), 0);
        chk("reset busy", int'(bus.busy), 0);

        vecs[0] = '{8'hFF, 0, 0, 0};
        vecs[1] = '{8'hA5, 100, 0, 1800};
        vecs[2] = '{8'hFF, 0, 28672, 229376};
        vecs[3] = '{8'hFF, 0, -28672, -229376};
        vecs[4] = '{8'h00, 100, 0, 0};
        vecs[5] = '{8'h01, 0, 10, 10};
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < N; i++) wr_w(i, vecs[v].wmul * (i + 1) + vecs[v].wadd);
            run_ts(vecs[v].spk, lat);
            chk($sformatf("vec%0d value", v), int'(bus.spiking_value), clamp(vecs[v].raw - LEAK_V));
            chk($sformatf("vec%0d latency", v), lat, N + 1);
            chk($sformatf("vec%0d busy at valid", v), int'(bus.busy), 0);
            tick();
            chk($sformatf("vec%0d single pulse", v), int'(bus.out_valid), 0);
        end

        // Second 1800 timestep: a neuron with threshold 2400 would fire here.
        for (int i = 0; i < N; i++) wr_w(i, 100 * (i + 1));
        run_ts(8'hA5, lat);
        run_ts(8'hA5, lat);
        chk("repeat 1800", int'(bus.spiking_value), clamp(1800 - LEAK_V));

        // Starts while busy are dropped.
        bus.start = 1'b1;
        bus.in_spikes = 8'h0F;
        tick();
        bus.start = 1'b0;
        bus.in_spikes = 8'hF0;
        repeat (2) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        pulses = 0;
        val = 0;
        for (int c = 0; c < 30; c++) begin
            if (bus.out_valid) begin
                pulses++;
                val = int'(bus.spiking_value);
            end
            tick();
        end
        chk("busy start pulses", pulses, 1);
        chk("busy start value", val, expect_of(8'h0F));

        // Start in the out_valid cycle is accepted.
        run_ts(8'h03, lat);
        chk("b2b first value", int'(bus.spiking_value), expect_of(8'h03));
        run_ts(8'h30, lat);
        chk("b2b second latency", lat, N + 1);
        chk("b2b second value", int'(bus.spiking_value), expect_of(8'h30));

        // Write to w[2] in the same cycle ACCUM reads idx 2.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < N; i++) w_model[i] = 0;
        wr_w(2, 10);
        bus.start = 1'b1;
        bus.in_spikes = 8'h04;
        tick();
        bus.start = 1'b0;
        repeat (2) tick();
        bus.wr_en = 1'b1;
        bus.wr_addr = 3'd2;
        bus.wr_data = 16'sd50;
        tick();
        bus.wr_en = 1'b0;
        w_model[2] = 50;
        wait_valid(lat);
        chk("collision old weight", int'(bus.spiking_value), clamp(10 - LEAK_V));
        run_ts(8'h04, lat);
        chk("collision new weight", int'(bus.spiking_value), clamp(50 - LEAK_V));

        // Reset while ACCUM is at idx 4.
        for (int i = 0; i < N; i++) wr_w(i, 1000);
        bus.start = 1'b1;
        bus.in_spikes = 8'hFF;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < N; i++) w_model[i] = 0;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.out_valid) pulses++;
            tick();
        end
        chk("abort no pulse", pulses, 0);
        chk("abort busy", int'(bus.busy), 0);
        chk("abort value", int'(bus.spiking_value), 0);
        run_ts(8'hFF, lat);
        chk("abort weights cleared", int'(bus.spiking_value), clamp(0 - LEAK_V));

        for (int r = 0; r < 25; r++) begin
            repeat ($urandom_range(1, 4)) begin
                if ($urandom_range(0, 1) == 1) wr_w($urandom_range(0, N - 1), int'($urandom_range(0, 65535)) - 32768);
                else wr_w($urandom_range(0, N - 1), int'($urandom_range(0, 1000)) - 500);
            end
            spk = 8'($urandom);
            run_ts(spk, lat);
            chk($sformatf("rand%0d value", r), int'(bus.spiking_value), expect_of(spk));
            chk($sformatf("rand%0d latency", r), lat, N + 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
